// File: rtl/layer_compositor.sv
// N-layer priority compositor: qualify stage, select stage, RGB332 -> RGB888 expansion.
// Optional colour-key transparency is compiled in with LAYER_COMPOSITOR_COLORKEY_EN.
module layer_compositor #(
    parameter int unsigned NUM_LAYERS   = 12,
    parameter logic [7:0]  COLOR_KEY    = 8'hFF,
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic [NUM_LAYERS-1:0]         layer_dr,
    input  logic [8*NUM_LAYERS-1:0]       layer_rgb,
    input  logic [7:0]                    backGroundRGB,
    input  logic                          frame_tick,
    input  logic                          cfg_we,
    input  logic [NUM_LAYERS-1:0]         cfg_layer_en,
    input  logic [NUM_LAYERS-1:0]         cfg_blink_mask,
    output logic [7:0]                    redOut,
    output logic [7:0]                    greenOut,
    output logic [7:0]                    blueOut,
    output logic [$clog2(NUM_LAYERS)-1:0] winner_idx,
    output logic                          winner_valid
);

    localparam int unsigned IdxW      = $clog2(NUM_LAYERS);
    localparam logic [7:0]  BlinkLast = 8'(BLINK_FRAMES - 1);

    logic [NUM_LAYERS-1:0]   layer_en_q, layer_en_d;
    logic [NUM_LAYERS-1:0]   blink_mask_q, blink_mask_d;
    logic [7:0]              frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    logic [NUM_LAYERS-1:0]   keyed;
    logic [NUM_LAYERS-1:0]   eligible;
    logic [NUM_LAYERS-1:0]   elig_q;
    logic [8*NUM_LAYERS-1:0] rgb_q;
    logic [7:0]              bg_q;

    logic [7:0]              sel_color;
    logic [IdxW-1:0]         win_idx_d, win_idx_q;
    logic                    win_valid_d, win_valid_q;
    logic [7:0]              red_d, green_d, blue_d;
    logic [7:0]              red_q, green_q, blue_q;

    always_comb begin
        layer_en_d    = layer_en_q;
        blink_mask_d  = blink_mask_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (cfg_we) begin
            layer_en_d   = cfg_layer_en;
            blink_mask_d = cfg_blink_mask;
        end
        if (frame_tick) begin
            if (frame_cnt_q == BlinkLast) begin
                frame_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

`ifdef LAYER_COMPOSITOR_COLORKEY_EN
    always_comb begin
        keyed = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            keyed[i] = (layer_rgb[8*i +: 8] == COLOR_KEY);
        end
    end
`else
    always_comb begin
        keyed = '0;
    end
`endif

    always_comb begin
        eligible = layer_dr & layer_en_q & ~(blink_mask_q & {NUM_LAYERS{blink_phase_q}}) & ~keyed;
    end

    // Scan from lowest priority upward so the lowest eligible index is the last write.
    always_comb begin
        win_valid_d = 1'b0;
        win_idx_d   = '0;
        sel_color   = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (elig_q[i]) begin
                win_valid_d = 1'b1;
                win_idx_d   = IdxW'(i);
                sel_color   = rgb_q[8*i +: 8];
            end
        end
        red_d   = {sel_color[7:5], sel_color[7:5], sel_color[7:6]};
        green_d = {sel_color[4:2], sel_color[4:2], sel_color[4:3]};
        blue_d  = {sel_color[1:0], sel_color[1:0], sel_color[1:0], sel_color[1:0]};
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            layer_en_q    <= '1;
            blink_mask_q  <= '0;
            frame_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
            elig_q        <= '0;
            rgb_q         <= '0;
            bg_q          <= 8'd0;
            win_idx_q     <= '0;
            win_valid_q   <= 1'b0;
            red_q         <= 8'd0;
            green_q       <= 8'd0;
            blue_q        <= 8'd0;
        end else begin
            layer_en_q    <= layer_en_d;
            blink_mask_q  <= blink_mask_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            elig_q        <= eligible;
            rgb_q         <= layer_rgb;
            bg_q          <= backGroundRGB;
            win_idx_q     <= win_idx_d;
            win_valid_q   <= win_valid_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign redOut       = red_q;
    assign greenOut     = green_q;
    assign blueOut      = blue_q;
    assign winner_idx   = win_idx_q;
    assign winner_valid = win_valid_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor (4 layers, 2-frame blink): directed literal
// checks plus a randomized stream compared every cycle against a 2-cycle-delayed model.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int BF = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [1:0] idx;
        logic       v;
    } out_t;

    logic          clk = 1'b0;
    logic          resetN;
    logic [NL-1:0] layer_dr;
    logic [8*NL-1:0] layer_rgb;
    logic [7:0]    backGroundRGB;
    logic          frame_tick;
    logic          cfg_we;
    logic [NL-1:0] cfg_layer_en;
    logic [NL-1:0] cfg_blink_mask;
    logic [7:0]    redOut, greenOut, blueOut;
    logic [1:0]    winner_idx;
    logic          winner_valid;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    layer_compositor #(
        .NUM_LAYERS  (NL),
        .COLOR_KEY   (8'hFF),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .layer_dr      (layer_dr),
        .layer_rgb     (layer_rgb),
        .backGroundRGB (backGroundRGB),
        .frame_tick    (frame_tick),
        .cfg_we        (cfg_we),
        .cfg_layer_en  (cfg_layer_en),
        .cfg_blink_mask(cfg_blink_mask),
        .redOut        (redOut),
        .greenOut      (greenOut),
        .blueOut       (blueOut),
        .winner_idx    (winner_idx),
        .winner_valid  (winner_valid)
    );

    always #5 clk = ~clk;

    // Model: 3-bit and 2-bit channels scale to 0..255 by rounded proportion.
    function automatic logic [7:0] scale3(int a);
        return 8'((a * 255 + 3) / 7);
    endfunction

    function automatic logic [7:0] scale2(int b);
        return 8'(b * 85);
    endfunction

    function automatic bit is_key(logic [7:0] c);
`ifdef LAYER_COMPOSITOR_COLORKEY_EN
        return c == 8'hFF;
`else
        return 1'b0;
`endif
    endfunction

    logic [NL-1:0] m_en, m_mask;
    int            m_cnt;
    bit            m_ph;
    out_t          p1, p2;

    always @(posedge clk) begin
        out_t       cur;
        int         w;
        logic [7:0] c;
        if (resetN) begin
            m_en = '1; m_mask = '0; m_cnt = 0; m_ph = 1'b0;
            p1 = '0; p2 = '0;
        end else begin
            w = -1;
            for (int i = 0; i < NL; i++) begin
                if (w < 0 && layer_dr[i] && m_en[i] && !(m_mask[i] && m_ph) &&
                    !is_key(layer_rgb[8*i +: 8])) w = i;
            end
            c = backGroundRGB;
            if (w >= 0) c = layer_rgb[8*w +: 8];
            cur.r   = scale3(int'(c[7:5]));
            cur.g   = scale3(int'(c[4:2]));
            cur.b   = scale2(int'(c[1:0]));
            cur.idx = (w >= 0) ? 2'(w) : 2'd0;
            cur.v   = (w >= 0);
            p2 = p1;
            p1 = cur;
            if (cfg_we) begin
                m_en = cfg_layer_en;
                m_mask = cfg_blink_mask;
            end
            if (frame_tick) begin
                m_cnt++;
                if (m_cnt == BF) begin
                    m_cnt = 0;
                    m_ph = ~m_ph;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if ({redOut, greenOut, blueOut, winner_idx, winner_valid} !== p2) begin
                errors++;
                $display("FAIL stream t=%0t got rgb=%h%h%h idx=%0d v=%b want rgb=%h%h%h idx=%0d v=%b",
                         $time, redOut, greenOut, blueOut, winner_idx, winner_valid,
                         p2.r, p2.g, p2.b, p2.idx, p2.v);
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
    endtask

    initial begin
        resetN = 1'b1; layer_dr = '0; layer_rgb = '0; backGroundRGB = 8'h00;
        frame_tick = 1'b0; cfg_we = 1'b0; cfg_layer_en = '1; cfg_blink_mask = '0;
        step(2);
        chk("reset_red", int'(redOut), 0);
        chk("reset_valid", int'(winner_valid), 0);
        resetN = 1'b0;
        chk_on = 1'b1;

        // Priority
        layer_dr = 4'b1010; layer_rgb = {8'hE0, 8'h00, 8'h1C, 8'h00};
        step(2);
        chk("prio_green", int'(greenOut), 'hFF);
        chk("prio_red", int'(redOut), 'h00);
        chk("prio_idx", int'(winner_idx), 1);
        chk("prio_valid", int'(winner_valid), 1);

        // Background, then reset mid-stream
        layer_dr = '0; backGroundRGB = 8'h03;
        step(2);
        chk("bg_blue", int'(blueOut), 'hFF);
        chk("bg_red", int'(redOut), 0);
        chk("bg_green", int'(greenOut), 0);
        chk("bg_valid", int'(winner_valid), 0);
        backGroundRGB = 8'hFF;
        step(2);
        resetN = 1'b1;
        step(1);
        chk("midrst_red", int'(redOut), 0);
        chk("midrst_blue", int'(blueOut), 0);
        resetN = 1'b0;

        // Enable mask
        cfg_we = 1'b1; cfg_layer_en = 4'b1101; cfg_blink_mask = '0;
        layer_dr = 4'b0011; layer_rgb = {8'h00, 8'h00, 8'h1C, 8'hE0};
        step(1);
        cfg_we = 1'b0;
        step(2);
        chk("mask_idx", int'(winner_idx), 0);
        chk("mask_red", int'(redOut), 'hFF);
        layer_dr = 4'b0010; backGroundRGB = 8'h03;
        step(2);
        chk("mask_valid", int'(winner_valid), 0);
        chk("mask_bgblue", int'(blueOut), 'hFF);

        // Blink
        cfg_we = 1'b1; cfg_layer_en = 4'b1111; cfg_blink_mask = 4'b0001;
        layer_dr = 4'b0001; layer_rgb = {8'h00, 8'h00, 8'h00, 8'hE0};
        step(1);
        cfg_we = 1'b0;
        tick(); tick();
        step(2);
        chk("blink_hidden", int'(winner_valid), 0);
        tick(); tick();
        step(2);
        chk("blink_back", int'(winner_valid), 1);
        chk("blink_back_red", int'(redOut), 'hFF);
        tick();
        frame_tick = 1'b1; cfg_we = 1'b1; cfg_blink_mask = 4'b0000;
        step(1);
        frame_tick = 1'b0; cfg_we = 1'b0;
        step(2);
        chk("blink_coinc_vis", int'(winner_valid), 1);
        cfg_we = 1'b1; cfg_blink_mask = 4'b0001;
        step(1);
        cfg_we = 1'b0;
        step(2);
        chk("blink_coinc_phase", int'(winner_valid), 0);

        // Colour key
        cfg_we = 1'b1; cfg_blink_mask = '0;
        step(1);
        cfg_we = 1'b0;
        layer_dr = 4'b0101; layer_rgb = {8'h00, 8'h1C, 8'h00, 8'hFF};
        step(2);
`ifdef LAYER_COMPOSITOR_COLORKEY_EN
        chk("key_idx", int'(winner_idx), 2);
        chk("key_green", int'(greenOut), 'hFF);
        chk("key_red", int'(redOut), 0);
`else
        chk("nokey_idx", int'(winner_idx), 0);
        chk("nokey_red", int'(redOut), 'hFF);
        chk("nokey_blue", int'(blueOut), 'hFF);
`endif

        // Random stream
        for (int n = 0; n < 1000; n++) begin
            layer_dr       = NL'($urandom);
            layer_rgb      = {$urandom};
            if ($urandom_range(0, 7) == 0) layer_rgb[7:0] = 8'hFF;
            backGroundRGB  = 8'($urandom);
            frame_tick     = ($urandom_range(0, 5) == 0);
            cfg_we         = ($urandom_range(0, 15) == 0);
            cfg_layer_en   = NL'($urandom);
            cfg_blink_mask = NL'($urandom);
            resetN         = ($urandom_range(0, 255) == 0);
            step(1);
        end
        resetN = 1'b0; frame_tick = 1'b0; cfg_we = 1'b0;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
